// File: rtl/tiny_rv_wb_arb_n.sv
// tiny_rv_wb_arb_n: N-master to 1-slave pipelined Wishbone B4 arbiter.
// Arbitration is fixed priority (RR=0, lowest index wins) or round-robin
// (RR=1). A grant is held until the owner drops CYC, and the arbiter
// re-arbitrates on that same edge, so a handoff costs no idle cycles.
// Optional watchdog: define TINY_RV_WB_ARB_TIMEOUT_EN to abort a transfer
// that has seen no ack/err for TIMEOUT cycles.
//
// state   | meaning
// --------+---------------------------------------------
// S_IDLE  | no master owns the bus, o_grant is zero
// S_GRANT | master gidx owns the bus until it drops CYC

module tiny_rv_wb_arb_n #(
  parameter int NM      = 2,
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int RR      = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NM-1:0]        i_m_cyc,
  input  logic [NM-1:0]        i_m_stb,
  input  logic [NM-1:0]        i_m_we,
  input  logic [NM*AW-1:0]     i_m_adr,
  input  logic [NM*DW-1:0]     i_m_dat,
  input  logic [NM*DW/8-1:0]   i_m_sel,
  output logic [NM-1:0]        o_m_ack,
  output logic [NM-1:0]        o_m_stall,
  output logic [NM-1:0]        o_m_err,
  output logic [DW-1:0]        o_m_dat,
  output logic                 o_cyc,
  output logic                 o_stb,
  output logic                 o_we,
  output logic [AW-1:0]        o_adr,
  output logic [DW-1:0]        o_dat,
  output logic [DW/8-1:0]      o_sel,
  input  logic                 i_ack,
  input  logic                 i_stall,
  input  logic                 i_err,
  input  logic [DW-1:0]        i_dat,
  output logic [NM-1:0]        o_grant
);

  localparam int SW = DW / 8;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [NM-1:0] GRANT_ONE = {{(NM-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t        state;
  logic [IW-1:0] gidx;
  logic [IW-1:0] rr_ptr;

  logic          granted;
  logic          cur_cyc;
  logic          any_req;
  logic [IW-1:0] rel_ptr;
  logic [IW-1:0] arb_start;
  logic [IW-1:0] arb_idx;
  logic [IW-1:0] sel_idx;
  logic          wd_hit;
  logic          wd_kill;

  // First requester found searching upward from start, wrapping at NM-1.
  function automatic logic [IW-1:0] pick(input logic [NM-1:0] req,
                                         input logic [IW-1:0] start);
    logic [IW-1:0] idx;
    logic          found;
    int            p;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NM; i++) begin
      p = int'(start) + i;
      if (p >= NM) p = p - NM;
      if (!found && req[IW'(p)]) begin
        idx   = IW'(p);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign granted = (state == S_GRANT);
  assign cur_cyc = i_m_cyc[gidx];
  assign any_req = |i_m_cyc;
  assign rel_ptr = (gidx == IW'(NM - 1)) ? '0 : gidx + IW'(1);

  // Search start: the RR pointer when idle, the post-release pointer on a
  // handoff (so the releasing master goes to the back of the line).
  always_comb begin
    arb_start = '0;
    if (RR != 0) arb_start = granted ? rel_ptr : rr_ptr;
    arb_idx = pick(i_m_cyc, arb_start);
  end

  // Grant FSM: acquire from idle, hold while owner keeps CYC, hand off on release.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      gidx    <= '0;
      rr_ptr  <= '0;
      o_grant <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state   <= S_GRANT;
            gidx    <= arb_idx;
            o_grant <= GRANT_ONE << arb_idx;
          end
        end
        S_GRANT: begin
          if (!cur_cyc) begin
            if (RR != 0) rr_ptr <= rel_ptr;
            if (any_req) begin
              gidx    <= arb_idx;
              o_grant <= GRANT_ONE << arb_idx;
            end else begin
              state   <= S_IDLE;
              o_grant <= '0;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          o_grant <= '0;
        end
      endcase
    end
  end

`ifdef TINY_RV_WB_ARB_TIMEOUT_EN
  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_cnt;
  logic           wd_kill_q;

  assign wd_hit  = granted && cur_cyc && (wd_cnt == WDW'(TIMEOUT));
  assign wd_kill = wd_kill_q;

  // Watchdog: counts live bus cycles without a response; a hit errors the
  // owner and drops CYC for one cycle, then counting restarts from zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wd_cnt    <= '0;
      wd_kill_q <= 1'b0;
    end else if (!granted || !cur_cyc) begin
      wd_cnt    <= '0;
      wd_kill_q <= 1'b0;
    end else begin
      wd_kill_q <= wd_hit;
      if (wd_hit || i_ack || i_err)
        wd_cnt <= '0;
      else if (!wd_kill_q)
        wd_cnt <= wd_cnt + WDW'(1);
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign wd_kill = 1'b0;
`endif

  assign sel_idx = granted ? gidx : '0;

  // Slave-side request mux; master 0 drives the bus fields while idle.
  always_comb begin
    o_we  = i_m_we[0];
    o_adr = i_m_adr[0 +: AW];
    o_dat = i_m_dat[0 +: DW];
    o_sel = i_m_sel[0 +: SW];
    for (int k = 1; k < NM; k++) begin
      if (sel_idx == IW'(k)) begin
        o_we  = i_m_we[k];
        o_adr = i_m_adr[k*AW +: AW];
        o_dat = i_m_dat[k*DW +: DW];
        o_sel = i_m_sel[k*SW +: SW];
      end
    end
  end

  assign o_cyc   = granted && cur_cyc && !wd_kill;
  assign o_stb   = o_cyc && i_m_stb[gidx];
  assign o_m_dat = i_dat;

  // Response routing: only the owner sees ack/err/stall; everyone else is stalled.
  always_comb begin
    o_m_ack   = '0;
    o_m_err   = '0;
    o_m_stall = '1;
    if (granted) begin
      o_m_ack[gidx]   = i_ack && cur_cyc;
      o_m_err[gidx]   = (i_err && cur_cyc) || wd_hit;
      o_m_stall[gidx] = i_stall;
    end
  end

endmodule

// File: tb/tb_tiny_rv_wb_arb_n.sv
// Bench for tiny_rv_wb_arb_n: one fixed-priority and one round-robin
// instance share all stimulus; an integer-level owner/pointer model
// predicts every output each cycle, plus directed scenario checks.
// Honours TINY_RV_WB_ARB_TIMEOUT_EN for the watchdog expectations.

module tb_tiny_rv_wb_arb_n;
  localparam int NM = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
`ifdef TINY_RV_WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int WD_LIM = TO_EN ? 40 : 1000;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*SW-1:0] m_sel;
  logic             s_ack, s_stall, s_err;
  logic [DW-1:0]    s_dat;

  logic [NM-1:0] ack_a [2];
  logic [NM-1:0] stall_a [2];
  logic [NM-1:0] err_a [2];
  logic [NM-1:0] grant_a [2];
  logic [DW-1:0] mdat_a [2];
  logic          cyc_a [2];
  logic          stb_a [2];
  logic          we_a [2];
  logic [AW-1:0] adr_a [2];
  logic [DW-1:0] dat_a [2];
  logic [SW-1:0] sel_a [2];

  int total = 0;
  int bad = 0;

  // model state: owner (-1 idle), RR pointer, watchdog count, kill cycle
  int own [2];
  int ptr [2];
  int wd [2];
  bit kill [2];

  int ord [4] = '{0, 1, 2, 0};
  int accepted, remaining, n, first;

  always #5 clk = ~clk;

  tiny_rv_wb_arb_n #(.NM(NM), .AW(AW), .DW(DW), .RR(0), .TIMEOUT(TO)) u_fp (
    .i_clk(clk), .i_reset(rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
    .o_m_ack(ack_a[0]), .o_m_stall(stall_a[0]), .o_m_err(err_a[0]),
    .o_m_dat(mdat_a[0]),
    .o_cyc(cyc_a[0]), .o_stb(stb_a[0]), .o_we(we_a[0]),
    .o_adr(adr_a[0]), .o_dat(dat_a[0]), .o_sel(sel_a[0]),
    .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err), .i_dat(s_dat),
    .o_grant(grant_a[0])
  );

  tiny_rv_wb_arb_n #(.NM(NM), .AW(AW), .DW(DW), .RR(1), .TIMEOUT(TO)) u_rr (
    .i_clk(clk), .i_reset(rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
    .o_m_ack(ack_a[1]), .o_m_stall(stall_a[1]), .o_m_err(err_a[1]),
    .o_m_dat(mdat_a[1]),
    .o_cyc(cyc_a[1]), .o_stb(stb_a[1]), .o_we(we_a[1]),
    .o_adr(adr_a[1]), .o_dat(dat_a[1]), .o_sel(sel_a[1]),
    .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err), .i_dat(s_dat),
    .o_grant(grant_a[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // first requester at or after start (wrapping); inst 0 always starts at 0
  function automatic int pick_ref(input int inst, input int start);
    int st = (inst == 0) ? 0 : start;
    for (int i = 0; i < NM; i++)
      if (m_cyc[(st + i) % NM]) return (st + i) % NM;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      own[i] = -1; ptr[i] = 0; wd[i] = 0; kill[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (own[i] < 0) begin
        if (|m_cyc) begin
          own[i] = pick_ref(i, ptr[i]); wd[i] = 0; kill[i] = 1'b0;
        end
      end else if (!m_cyc[own[i]]) begin
        if (i == 1) ptr[i] = (own[i] + 1) % NM;
        own[i] = pick_ref(i, ptr[i]); wd[i] = 0; kill[i] = 1'b0;
      end else if (TO_EN) begin
        bit hit = (wd[i] == TO);
        bit live = !kill[i];
        if (hit || s_ack || s_err) wd[i] = 0;
        else if (live) wd[i] = wd[i] + 1;
        kill[i] = hit;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int g = own[i];
      bit ga = (g >= 0);
      int s = ga ? g : 0;
      bit ce = ga && m_cyc[s] && !kill[i];
      bit hit = TO_EN && ga && m_cyc[s] && (wd[i] == TO);
      logic [NM-1:0] eg = '0, ea = '0, ee = '0, es = '1;
      if (ga) begin
        eg[s] = 1'b1;
        ea[s] = s_ack && m_cyc[s];
        ee[s] = (s_err && m_cyc[s]) || hit;
        es[s] = s_stall;
      end
      chk($sformatf("cyc%0d", i), 64'(cyc_a[i]), 64'(ce));
      chk($sformatf("stb%0d", i), 64'(stb_a[i]), 64'(ce && m_stb[s]));
      chk($sformatf("grant%0d", i), 64'(grant_a[i]), 64'(eg));
      chk($sformatf("ack%0d", i), 64'(ack_a[i]), 64'(ea));
      chk($sformatf("err%0d", i), 64'(err_a[i]), 64'(ee));
      chk($sformatf("stall%0d", i), 64'(stall_a[i]), 64'(es));
      chk($sformatf("req%0d", i), 64'({we_a[i], sel_a[i], adr_a[i]}),
          64'({m_we[s], m_sel[s*SW +: SW], m_adr[s*AW +: AW]}));
      chk($sformatf("wdat%0d", i), 64'(dat_a[i]), 64'(m_dat[s*DW +: DW]));
      chk($sformatf("rdat%0d", i), 64'(mdat_a[i]), 64'(s_dat));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hung expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0; s_dat = 32'h1234_5678;
    model_reset();
    #2;
    chk("rst_cyc", 64'(cyc_a[0]), 64'd0);
    chk("rst_grant", 64'(grant_a[0]), 64'd0);
    chk("rst_ack", 64'(ack_a[0]), 64'd0);
    chk("rst_err", 64'(err_a[1]), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset in the middle of a grant acts without a clock edge
    m_cyc = 3'b010; m_stb = 3'b010;
    cycle();
    chk("mid_grant", 64'(grant_a[0]), 64'b010);
    cycle();
    rst = 1'b1;
    #1;
    chk("mid_rst_cyc", 64'(cyc_a[0]), 64'd0);
    chk("mid_rst_grant", 64'(grant_a[0]), 64'd0);
    chk("mid_rst_grant_rr", 64'(grant_a[1]), 64'd0);
    model_reset();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cyc = 3'b001; m_stb = 3'b001;
    cycle();
    chk("post_rst_grant", 64'(grant_a[0]), 64'b001);
    chk("post_rst_cyc", 64'(cyc_a[0]), 64'd1);
    m_cyc = '0;
    cycle();
    cycle();

    // fixed priority with zero-idle handoff
    m_cyc = 3'b101; m_stb = 3'b101;
    cycle();
    chk("fp_first", 64'(grant_a[0]), 64'b001);
    s_ack = 1'b1;
    repeat (4) cycle();
    s_ack = 1'b0;
    m_cyc[0] = 1'b0;
    cycle();
    chk("fp_handoff", 64'(grant_a[0]), 64'b100);
    chk("fp_handoff_cyc", 64'(cyc_a[0]), 64'd1);
    m_cyc = '0;
    cycle();
    cycle();

    // round-robin ordering
    apply_reset();
    m_cyc = 3'b111; m_stb = 3'b111;
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_order%0d", i), 64'(grant_a[1]), 64'(3'b001 << ord[i]));
      s_ack = 1'b1;
      cycle();
      s_ack = 1'b0;
      m_cyc[ord[i]] = 1'b0;
      cycle();
      m_cyc[ord[i]] = 1'b1;
    end
    m_cyc = '0; m_stb = '0;
    cycle();
    cycle();

    // stall passthrough: 3 pipelined strobes, 2 stalled cycles first
    apply_reset();
    m_cyc = 3'b011; m_stb = 3'b011;
    cycle();
    accepted = 0; remaining = 3; n = 0;
    while (remaining > 0 && n < 12) begin
      s_stall = (n < 2);
      #1;
      if (stb_a[0] && !s_stall) accepted++;
      chk("stall_mirror", 64'(stall_a[0][0]), 64'(s_stall));
      chk("stall_other", 64'(stall_a[0][1]), 64'd1);
      cycle();
      if (!s_stall) remaining--;
      if (remaining == 0) m_stb = 3'b010;
      n++;
    end
    chk("stall_accepted", 64'(accepted), 64'd3);
    chk("stall_cycles", 64'(n), 64'd5);
    s_stall = 1'b0;
    m_cyc = '0; m_stb = '0;
    cycle();
    cycle();

    // error routing to master 1
    apply_reset();
    m_cyc = 3'b010; m_stb = 3'b010;
    cycle();
    s_ack = 1'b1;
    #1;
    chk("err_first_ack", 64'(ack_a[0]), 64'b010);
    chk("err_first_err", 64'(err_a[0]), 64'b000);
    cycle();
    s_ack = 1'b0; s_err = 1'b1;
    #1;
    chk("err_route", 64'(err_a[0]), 64'b010);
    chk("err_no_ack", 64'(ack_a[0]), 64'b000);
    cycle();
    s_err = 1'b0; m_stb = '0;
    #1;
    chk("err_pulse_end", 64'(err_a[0]), 64'b000);
    cycle();
    m_cyc = '0;
    cycle();

    // watchdog: slave never responds
    apply_reset();
    m_cyc = 3'b001; m_stb = 3'b001;
    cycle();
    first = -1;
    for (int k = 0; k < WD_LIM; k++) begin
      #1;
      if (first >= 0 && k == first + 1) chk("wd_kill_cyc", 64'(cyc_a[0]), 64'd0);
      if (first < 0 && err_a[0][0]) first = k;
      cycle();
    end
    chk("wd_first_err", 64'(first), TO_EN ? 64'(TO) : 64'(-1));
    m_cyc = '0; m_stb = '0;
    cycle();
    cycle();

    // randomized traffic against the model
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(0, 5) == 0) m_cyc[k] = ~m_cyc[k];
        m_stb[k] = 1'($urandom);
        m_we[k]  = 1'($urandom);
        m_adr[k*AW +: AW] = AW'($urandom);
        m_dat[k*DW +: DW] = $urandom;
        m_sel[k*SW +: SW] = SW'($urandom);
      end
      s_ack   = ($urandom_range(0, 2) == 0);
      s_err   = ($urandom_range(0, 9) == 0);
      s_stall = 1'($urandom);
      s_dat   = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
